// File: rtl/count_sampler_if.sv
// Sample-capture and FIFO-output stream shared by count_sampler and its user.
// The master side supplies counts and the consumer ready. The slave side returns the FIFO head.
interface count_sampler_if;
  logic [3:0] cnt_in;
  logic       sample_en;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output cnt_in,
    output sample_en,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  cnt_in,
    input  sample_en,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/count_sampler.sv
// Samples an upstream 4-bit counter into a first-word-fall-through FIFO and flags counter wraps.
// Optional feature: define COUNT_SAMPLER_WRAP_CNT_EN to add the 8-bit wrap_count port and its counter.
module count_sampler #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  count_sampler_if.slave           bus,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     full,
  output logic                     overflow,
  output logic                     wrap_pulse
`ifdef COUNT_SAMPLER_WRAP_CNT_EN
  ,
  output logic [7:0]               wrap_count
`endif
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_C = DEPTH[AW:0];

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("count_sampler: DEPTH must be a power of two in 2..16");
  end

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [3:0]    prev_cnt_q;
  logic          prev_ok_q;
  logic          wrap_pulse_q;

  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic          wrap_seen;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  assign pop   = !empty && bus.out_ready;
  // A full FIFO still accepts a sample when the head leaves on the same edge.
  assign push  = bus.sample_en && (!full || pop);
  assign drop  = bus.sample_en && full && !pop;

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 4'h0 : mem[rd_ptr_q];
  assign fill_level    = count_q;
  assign overflow      = overflow_q;
  assign wrap_pulse    = wrap_pulse_q;

  // NOTE: the storage array has no reset. out_data is masked while empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.cnt_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // prev_ok blocks a false wrap on the first edge, when prev_cnt is only the reset value.
  assign wrap_seen = prev_ok_q && (prev_cnt_q == 4'hF) && (bus.cnt_in == 4'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cnt_q   <= 4'h0;
      prev_ok_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      prev_cnt_q   <= bus.cnt_in;
      prev_ok_q    <= 1'b1;
      wrap_pulse_q <= wrap_seen;
    end
  end

`ifdef COUNT_SAMPLER_WRAP_CNT_EN
  logic [7:0] wrap_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_count_q <= 8'h00;
    end else if (wrap_pulse_q) begin
      wrap_count_q <= wrap_count_q + 8'h01;
    end
  end

  assign wrap_count = wrap_count_q;
`endif

endmodule

// File: tb/tb_count_sampler.sv
// Directed bench for count_sampler: the stimulus pushes expected FIFO samples into a queue.
// A negedge monitor pops and compares the queue whenever the head is accepted.
module tb_count_sampler;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [$clog2(DEPTH):0] fill_level;
  logic                   full;
  logic                   overflow;
  logic                   wrap_pulse;
`ifdef COUNT_SAMPLER_WRAP_CNT_EN
  logic [7:0]             wrap_count;
`endif

  count_sampler_if bus ();

  count_sampler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fill_level (fill_level),
    .full       (full),
    .overflow   (overflow),
    .wrap_pulse (wrap_pulse)
`ifdef COUNT_SAMPLER_WRAP_CNT_EN
    ,
    .wrap_count (wrap_count)
`endif
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a head accepted on the coming edge must match the oldest expected sample.
  always @(negedge clk) begin : monitor
    logic [3:0] e;
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL head_unexpected: got %0h expected none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("head_data", bus.out_data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] v, input bit accept);
    bus.cnt_in    = v;
    bus.sample_en = 1'b1;
    if (accept) exp_q.push_back(v);
    tick();
    bus.sample_en = 1'b0;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [3:0] prev;
    logic [3:0] v;
    int         wraps;

    rst           = 1'b0;
    bus.cnt_in    = 4'h0;
    bus.sample_en = 1'b0;
    bus.out_ready = 1'b0;

    // Values held during reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_fill", fill_level, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wrap", wrap_pulse, 0);
    check("rst_data", bus.out_data, 0);

    // The first edge after release accepts a write, and the sample falls through on the next cycle.
    @(negedge clk);
    rst = 1'b1;
    write(4'h5, 1'b1);
    check("first_valid", bus.out_valid, 1);
    check("first_data", bus.out_data, 4'h5);
    check("first_fill", fill_level, 1);
    bus.out_ready = 1'b1;
    tick();
    check("first_drain_fill", fill_level, 0);
    check("first_drain_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Fill to full, then overflow on the fifth write.
    for (int i = 1; i <= 5; i++) begin
      write(4'(i), i <= 4);
      if (i == 4) begin
        check("fill4_full", full, 1);
        check("fill4_level", fill_level, 4);
        check("fill4_overflow", overflow, 0);
      end
      if (i == 5) begin
        check("ovf_flag", overflow, 1);
        check("ovf_level", fill_level, 4);
        check("ovf_full", full, 1);
      end
    end
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("drain_valid", bus.out_valid, 0);
    check("drain_fill", fill_level, 0);
    check("drain_full", full, 0);
    check("ovf_sticky", overflow, 1);
    bus.out_ready = 1'b0;

    // Asynchronous reset between edges with three samples stored.
    write(4'h7, 1'b1);
    write(4'h8, 1'b1);
    write(4'h6, 1'b1);
    check("pre_rst_fill", fill_level, 3);
    #3;
    rst        = 1'b0;
    bus.cnt_in = 4'hF;
    exp_q.delete();
    #1;
    check("async_valid", bus.out_valid, 0);
    check("async_fill", fill_level, 0);
    check("async_overflow", overflow, 0);
    check("async_data", bus.out_data, 0);
    @(negedge clk);
    rst        = 1'b1;
    bus.cnt_in = 4'h0;
    tick();
    check("post_rst_wrap0", wrap_pulse, 0);
    tick();
    check("post_rst_wrap1", wrap_pulse, 0);

    // A full FIFO with a write and a pop on the same edge keeps its level and does not overflow.
    for (int i = 1; i <= 4; i++) write(4'(i), 1'b1);
    check("full_again", full, 1);
    bus.out_ready = 1'b1;
    write(4'h9, 1'b1);
    check("sim_fill", fill_level, 4);
    check("sim_overflow", overflow, 0);
    repeat (4) tick();
    check("sim_drain_fill", fill_level, 0);

    // Free-running counter over 40 edges while samples stream through.
    prev  = bus.cnt_in;
    wraps = 0;
    for (int k = 0; k < 40; k++) begin
      v             = 4'((k + 1) % 16);
      bus.cnt_in    = v;
      bus.sample_en = 1'b1;
      exp_q.push_back(v);
      tick();
      check("wrap_cycle", wrap_pulse, (prev == 4'hF && v == 4'h0) ? 1 : 0);
      if (wrap_pulse === 1'b1) wraps++;
      prev = v;
    end
    bus.sample_en = 1'b0;
    check("wrap_total", wraps, 2);
`ifdef COUNT_SAMPLER_WRAP_CNT_EN
    check("wrap_count", wrap_count, 8'h02);
`endif
    tick();
    check("stream_fill", fill_level, 0);
    check("stream_overflow", overflow, 0);

    // out_ready held high on an empty FIFO is ignored.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_fill", fill_level, 0);
      check("idle_valid", bus.out_valid, 0);
    end
    write(4'hA, 1'b1);
    check("a_valid", bus.out_valid, 1);
    check("a_data", bus.out_data, 4'hA);
    check("a_fill", fill_level, 1);
    tick();
    check("a_pop_fill", fill_level, 0);
    check("a_pop_valid", bus.out_valid, 0);

    check("scoreboard_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/count_sampler.md
COUNT_SAMPLER -- requirements
Module: count_sampler

Interface
REQ-001 Parameter DEPTH, default 4, sample FIFO depth; SHALL be a power of two, 2..16.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset; asynchronous, active-low; SHALL clear all state while low.
REQ-004 Port cnt_in  input  4  count value from the upstream 4-bit counter.
REQ-005 Port sample_en  input  1  capture request; cnt_in SHALL be written to the FIFO on this edge.
REQ-006 Port out_data  output  4  FIFO head sample.
REQ-007 Port out_valid  output  1  out_data holds a valid sample.
REQ-008 Port out_ready  input  1  consumer accepts the head sample.
REQ-009 Port fill_level  output  $clog2(DEPTH)+1  number of stored samples, 0..DEPTH.
REQ-010 Port full  output  1  fill_level == DEPTH.
REQ-011 Port overflow  output  1  sticky flag: a sample was dropped.
REQ-012 Port wrap_pulse  output  1  one-cycle pulse on an upstream wrap 4'hF -> 4'h0.

Function
REQ-013 The FIFO SHALL be first-word fall-through: head on out_data whenever out_valid=1.
REQ-014 Write latency SHALL be one edge: a sample written on edge N SHALL appear with out_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-015 A pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL be ignored.
REQ-016 A write SHALL occur when sample_en=1 and (full=0 or a pop occurs on the same edge).
REQ-017 Simultaneous write and pop SHALL leave fill_level unchanged; when empty, only the write SHALL take effect.
REQ-018 sample_en=1 while full with no pop SHALL drop cnt_in, leave the FIFO unchanged, and set overflow=1.
REQ-019 overflow SHALL stay 1 until reset; it SHALL have no other clear.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; fill_level SHALL never exceed DEPTH or go below 0.
REQ-021 out_valid SHALL equal (fill_level != 0); full and out_valid SHALL derive from registered state only.
REQ-022 The block SHALL register cnt_in every edge as prev_cnt, with a prev_ok flag set on the first edge after reset.
REQ-023 wrap_pulse SHALL be 1 for exactly the cycle after an edge where prev_ok=1, prev_cnt=4'hF and cnt_in=4'h0; else 0.
REQ-024 No wrap_pulse SHALL occur on the first edge after reset release, whatever cnt_in is.
REQ-025 FIFO writes and wrap detection SHALL be independent; neither SHALL stall the other.

Reset
REQ-026 While rst=0: pointers=0, fill_level=0, out_valid=0, full=0, overflow=0, wrap_pulse=0, prev_ok=0, out_data=4'h0.
REQ-027 Reset asserted mid-operation SHALL discard all stored samples immediately, without waiting for a clock edge.
REQ-028 The first write SHALL be accepted on the first rising edge after rst goes high.

Configuration
REQ-029 Macro COUNT_SAMPLER_WRAP_CNT_EN defined: port wrap_count output 8 SHALL exist, increment on each wrap_pulse cycle, roll over 8'hFF -> 8'h00, and reset to 8'h00.
REQ-030 Macro undefined: port wrap_count and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then sample_en=1 for one edge with cnt_in=4'h5 -> next cycle out_valid=1, out_data=4'h5, fill_level=1.
REQ-032 DEPTH=4, out_ready=0, 5 writes of 1,2,3,4,5 -> full=1 after the 4th, overflow=1 after the 5th; draining yields 1,2,3,4 then out_valid=0.
REQ-033 Full FIFO, sample_en=1 and out_ready=1 on the same edge with cnt_in=4'h9 -> fill_level stays 4, overflow stays 0, 4'h9 is the last sample out.
REQ-034 Free-running upstream counter 0..F over 40 edges -> wrap_pulse high exactly twice, one cycle each, in the cycle after cnt_in shows 4'h0; with the macro, wrap_count=8'h02.
REQ-035 Assert rst low between clock edges with fill_level=3 -> out_valid=0, fill_level=0, overflow=0 at once; first post-reset cnt_in=4'h0 gives no wrap_pulse.
REQ-036 out_ready=1 with FIFO empty for 10 edges, then one write of 4'hA -> fill_level never negative; 4'hA is presented then popped, and fill_level returns to 0.
